// File: rtl/iomem_gpio_pkg.sv
// Shared constants for the iomem GPIO block: register offsets, reset values,
// and the byte-lane mask helper used by the write path.
package iomem_gpio_pkg;

  localparam logic [7:0] GPIO_DATA       = 8'h00;
  localparam logic [7:0] GPIO_OEB        = 8'h04;
  localparam logic [7:0] GPIO_PU         = 8'h08;
  localparam logic [7:0] GPIO_PD         = 8'h0C;
  localparam logic [7:0] GPIO_IRQ_EN     = 8'h10;
  localparam logic [7:0] GPIO_IRQ_EDGE   = 8'h14;
  localparam logic [7:0] GPIO_IRQ_STATUS = 8'h18;
  localparam logic [7:0] GPIO_OUT_RB     = 8'h1C;

  localparam logic [31:0] OEB_RST_VAL = 32'hFFFF_FFFF;

  // Cycles after reset release during which edge capture is held off.
  localparam logic [1:0] ARM_CYCLES = 2'd3;

  function automatic logic [31:0] lane_mask(input logic [3:0] wstrb);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

endpackage

// File: rtl/iomem_gpio_debounce.sv
// Single-pin debouncer: dout follows din only after DEBOUNCE_CYCLES
// consecutive cycles of disagreement; any reversion restarts the count.
module iomem_gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/iomem_gpio.sv
// Parametrised GPIO peripheral on the PicoSoC iomem bus with edge interrupts.
// Define IOMEM_GPIO_DEBOUNCE_EN to insert a per-pin debouncer after the synchroniser.
module iomem_gpio
  import iomem_gpio_pkg::*;
#(
  parameter int         NUM_PINS        = 8,
  parameter logic [7:0] BASE_SEL        = 8'h07,
  parameter int         DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oeb,
  output logic [NUM_PINS-1:0] gpio_pu,
  output logic [NUM_PINS-1:0] gpio_pd,
  output logic                irq
);

  localparam int N = NUM_PINS;

  logic [N-1:0] out_r, oeb_r, pu_r, pd_r, ien_r, iedge_r, ista_r;
  logic [N-1:0] sync1, sync2, filt, filt_q, edge_hit, w1c;
  logic [N-1:0] wd_n, wm_n;
  logic [31:0]  wmask, rd_mux;
  logic [7:0]   off;
  logic [1:0]   arm_cnt;
  logic         sel, wr, armed;

  assign sel   = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_SEL);
  assign wr    = sel && (iomem_wstrb != 4'b0000);
  assign off   = iomem_addr[7:0];
  assign wmask = lane_mask(iomem_wstrb);
  assign wm_n  = wmask[N-1:0];
  assign wd_n  = iomem_wdata[N-1:0];

  logic unused_bits;
  assign unused_bits = ^{iomem_addr[23:8], iomem_wdata, wmask};

  assign gpio_out = out_r;
  assign gpio_oeb = oeb_r;
  assign gpio_pu  = pu_r;
  assign gpio_pd  = pd_r & ~pu_r;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
    end
  end

`ifdef IOMEM_GPIO_DEBOUNCE_EN
  for (genvar i = 0; i < N; i++) begin : g_db
    iomem_gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .resetn (resetn),
      .din    (sync2[i]),
      .dout   (filt[i])
    );
  end
`else
  localparam int unused_db_cycles = DEBOUNCE_CYCLES;
  assign filt = sync2;
`endif

  // Pins already high at reset release would otherwise look like rising edges.
  assign armed    = (arm_cnt == ARM_CYCLES);
  assign edge_hit = armed ? ((filt & ~filt_q & ~iedge_r) | (~filt & filt_q & iedge_r)) : '0;
  assign w1c      = (wr && off == GPIO_IRQ_STATUS) ? (wd_n & wm_n) : '0;

  always_comb begin
    rd_mux = '0;
    case (off)
      GPIO_DATA:       rd_mux = 32'(filt);
      GPIO_OEB:        rd_mux = 32'(oeb_r);
      GPIO_PU:         rd_mux = 32'(pu_r);
      GPIO_PD:         rd_mux = 32'(pd_r);
      GPIO_IRQ_EN:     rd_mux = 32'(ien_r);
      GPIO_IRQ_EDGE:   rd_mux = 32'(iedge_r);
      GPIO_IRQ_STATUS: rd_mux = 32'(ista_r);
      GPIO_OUT_RB:     rd_mux = 32'(out_r);
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      out_r       <= '0;
      oeb_r       <= OEB_RST_VAL[N-1:0];
      pu_r        <= '0;
      pd_r        <= '0;
      ien_r       <= '0;
      iedge_r     <= '0;
      ista_r      <= '0;
      filt_q      <= '0;
      arm_cnt     <= '0;
      irq         <= 1'b0;
    end else begin
      iomem_ready <= sel;
      if (sel) iomem_rdata <= rd_mux;
      if (wr) begin
        case (off)
          GPIO_DATA:     out_r   <= (out_r   & ~wm_n) | (wd_n & wm_n);
          GPIO_OEB:      oeb_r   <= (oeb_r   & ~wm_n) | (wd_n & wm_n);
          GPIO_PU:       pu_r    <= (pu_r    & ~wm_n) | (wd_n & wm_n);
          GPIO_PD:       pd_r    <= (pd_r    & ~wm_n) | (wd_n & wm_n);
          GPIO_IRQ_EN:   ien_r   <= (ien_r   & ~wm_n) | (wd_n & wm_n);
          GPIO_IRQ_EDGE: iedge_r <= (iedge_r & ~wm_n) | (wd_n & wm_n);
          default: ;
        endcase
      end
      // A new edge on the clear cycle keeps the bit set.
      ista_r  <= (ista_r & ~w1c) | edge_hit;
      filt_q  <= filt;
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      irq     <= |(ista_r & ien_r);
    end
  end

endmodule

// File: doc/iomem_gpio.md
# iomem_gpio

Parametrised general-purpose I/O peripheral on the PicoSoC `iomem` bus, the successor to the fixed two-pin front-panel GPIO logic in the board top level. It provides per-pin output, direction, pull-up and pull-down control, and a 2-flop input synchroniser, for up to 32 pins. It also adds edge-triggered interrupts with sticky write-1-to-clear status and optional input debounce. It instantiates beside `picosoc` in the board top; `irq` feeds one of `irq_5..irq_7`.

## Interface
- `NUM_PINS`, 8, pin count, legal range 1..32.
- `BASE_SEL`, 8'h07, block selected when `iomem_addr[31:24] == BASE_SEL`.
- `DEBOUNCE_CYCLES`, 16, stable-cycle count; used only with the debounce feature; ≥1.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `iomem_valid`  in  1  bus request.
- `iomem_ready`  out  1  one-cycle acknowledge.
- `iomem_wstrb`  in  4  byte write strobes; 0 = read.
- `iomem_addr`  in  32  byte address.
- `iomem_wdata`  in  32  write data.
- `iomem_rdata`  out  32  read data, valid while `iomem_ready`=1.
- `gpio_in`  in  NUM_PINS  raw asynchronous pin inputs.
- `gpio_out`  out  NUM_PINS  output data.
- `gpio_oeb`  out  NUM_PINS  output enable, active-low; 1 = input.
- `gpio_pu`  out  NUM_PINS  pull-up enable.
- `gpio_pd`  out  NUM_PINS  pull-down enable.
- `irq`  out  1  level interrupt.

## Operation
- Register map, decoded on `iomem_addr[7:0]`:
  - 0x00 DATA: read returns filtered input; write sets OUT.
  - 0x04 OEB.
  - 0x08 PU.
  - 0x0C PD.
  - 0x10 IRQ_EN.
  - 0x14 IRQ_EDGE: 0 = rising, 1 = falling.
  - 0x18 IRQ_STATUS: write-1-to-clear.
  - 0x1C OUT readback.
- Other offsets in the window read 0, ignore writes, and are still acknowledged.
- Each byte lane is written only when its `iomem_wstrb` bit is set.
- Bits at index ≥ `NUM_PINS` read 0 and ignore writes.
- Reset values:
  - OUT, PU, PD, IRQ_EN, IRQ_EDGE, IRQ_STATUS = 0.
  - OEB = all ones.
  - `iomem_ready` = 0, `iomem_rdata` = 0, `irq` = 0.
  - Synchroniser and filter flops = 0.
- `gpio_pd = PD & ~PU`: pull-up wins if both are set.
- Edge detect compares the filtered input with its value one cycle earlier, and the selected edge sets the IRQ_STATUS bit.
- Edge capture is disarmed for the 3 cycles after reset release. This prevents spurious edges from pins that are already high.
- `irq` is registered: `irq <= |(IRQ_STATUS & IRQ_EN)`.
- Edge detect runs whether or not OEB is set, so driven outputs can self-interrupt.

## Timing
- Bus access:
  - `iomem_ready` rises the cycle after `iomem_valid`=1 with a matching select and `iomem_ready`=0.
  - It is high for exactly one cycle, then low for at least one cycle, even if `iomem_valid` stays high.
  - Writes take effect on the same edge that raises `iomem_ready`.
  - Read data is the pre-write value.
- Non-matching select: `iomem_ready` and `iomem_rdata` are untouched, leaving the bus to other slaves.
- Control registers drive `gpio_out/oeb/pu/pd` directly, with 0 cycles after the write edge.
- Input path: 2 cycles from a pin change to DATA, then +1 to IRQ_STATUS, then +1 to `irq`.
- A W1C to a status bit on the same cycle as a new edge on that bit leaves the bit set (set wins).
- Asserting `resetn`=0 mid-transaction clears `iomem_ready` immediately. The transaction is lost and the CPU re-issues it after reset.

## Configuration
- `IOMEM_GPIO_DEBOUNCE_EN` defined:
  - Each synchronised input passes through a debouncer.
  - The filtered value takes the new level only after `DEBOUNCE_CYCLES` consecutive cycles differing from the current filtered value.
  - Any reversion restarts the count.
  - Input latency becomes 2 + `DEBOUNCE_CYCLES` cycles.
- Not defined: filtered = synchronised, with no counters instantiated.

## Structure
- `iomem_gpio_pkg` holds the register offset constants (`GPIO_DATA`..`GPIO_OUT_RB`) and the OEB reset value.
- Sub-module `iomem_gpio_debounce`, one pin per instance, generated `NUM_PINS` times. Ports: `clk`, `resetn`, `din`, `dout`; counter width `$clog2(DEBOUNCE_CYCLES+1)`.

## Test plan
- Reset, then read 0x04 and 0x00 with NUM_PINS=8 → 0x000000FF and 0x00000000; `irq`=0; `gpio_oeb`=8'hFF.
- Write 0x00 with 0xA5 and `wstrb`=4'b0001, then read 0x1C → `gpio_out`=8'hA5 after the write edge, read returns 0xA5, `iomem_ready` is a single-cycle pulse.
- Write PU=0x0F and PD=0xFF → `gpio_pd`=8'hF0.
- IRQ_EN=0x01, IRQ_EDGE=0, raise `gpio_in[0]` → IRQ_STATUS=0x01 at +3 cycles, `irq`=1 at +4; W1C 0x01 → `irq`=0 the cycle after the clear.
- Falling-edge mode on pin 3 with a W1C on the same cycle as a new falling edge → IRQ_STATUS[3] stays 1.
- With `IOMEM_GPIO_DEBOUNCE_EN` and DEBOUNCE_CYCLES=4:
  - A 3-cycle glitch → DATA unchanged, no status.
  - A 6-cycle pulse → DATA updates 6 cycles after the pin change.
